key_debouncer: RTL and testbench
================================

# key_debouncer

Debounces the raw push-button inputs and drives the level-sensitive `in_port` of the keys PIO. That PIO performs edge capture and raises the interrupt. The block sits between the board key pins and the PIO.
- Two-flop synchronisation per key, then a per-key stability counter.
- A new level is accepted only after it has held for a programmable number of cycles.
- Key polarity stays active-low, so the PIO's falling-edge detect marks a press.
- One-cycle press and release strobes are provided for logic that does not go through the PIO.

## Interface
- NUM_KEYS, 3: number of independent key channels.
- CNT_WIDTH, 16: width of each stability counter.
- STABLE_CYCLES, 50000: consecutive cycles a new level must hold before acceptance (1 ms at 50 MHz). Constraints: 2 ≤ STABLE_CYCLES ≤ 2^CNT_WIDTH.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- keys_raw  input  NUM_KEYS  asynchronous raw key pins, active-low (0 = pressed).
- keys_db  output  NUM_KEYS  debounced level, active-low; connects to the PIO `in_port`.
- press_pulse  output  NUM_KEYS  one-cycle strobe when keys_db[i] goes 1→0.
- release_pulse  output  NUM_KEYS  one-cycle strobe when keys_db[i] goes 0→1.

## Operation
Each channel i is independent and identical, with the following state:
- sync1[i], sync2[i]: two-flop synchroniser.
- db[i]: accepted level, drives keys_db[i].
- cnt[i]: CNT_WIDTH-bit stability counter.
- Per-key FSM with two states:
  - STABLE: sync2 == db, cnt = 0.
  - PENDING: sync2 != db, cnt counting.

Transitions, evaluated every clock:
- STABLE, sync2 == db: stay; cnt held at 0.
- STABLE, sync2 != db: go to PENDING; cnt ← 1.
- PENDING, sync2 == db (bounce back): go to STABLE; cnt ← 0; db unchanged; no pulse.
- PENDING, sync2 != db, cnt < STABLE_CYCLES−1: cnt ← cnt+1.
- PENDING, sync2 != db, cnt == STABLE_CYCLES−1 (acceptance):
  - db ← sync2; cnt ← 0; go to STABLE.
  - Same edge: press_pulse[i] ← 1 if the new db is 0, else release_pulse[i] ← 1.
- press_pulse and release_pulse are registered. They are high for exactly the one cycle following the acceptance edge, otherwise 0.
- At most one of press_pulse[i] / release_pulse[i] is high in any cycle.
- The counter never exceeds STABLE_CYCLES−1 and never wraps.
- Simultaneous events on different keys are processed independently. Multiple pulse bits may be high in the same cycle.

Reset (reset high at a rising edge) dominates everything, including a pending acceptance in the same cycle:
- sync1, sync2, db ← all 1s (released).
- cnt ← 0; all FSMs → STABLE.
- press_pulse, release_pulse ← 0.
- No pulse is generated by reset itself.
- Reset mid-count discards the partial count.
- A key held pressed through reset is re-accepted as a normal press STABLE_CYCLES+2 edges after reset deasserts, with press_pulse asserted.

## Timing
- Reset values: keys_db = {NUM_KEYS{1'b1}}, press_pulse = 0, release_pulse = 0.
- Latency: keys_raw[i] changes before edge 0 and then holds.
  - sync2 reflects the change after edge 1.
  - cnt reaches STABLE_CYCLES−1 after edge STABLE_CYCLES.
  - keys_db[i] and the pulse update at edge STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges from the raw change.
- Glitch rejection: any reversal visible at sync2 before acceptance restarts the count. A glitch shorter than STABLE_CYCLES cycles never reaches keys_db.
- Minimum spacing between two accepted transitions on one key: STABLE_CYCLES cycles.
- No combinational path from keys_raw to any output.

## Test plan
Use STABLE_CYCLES=4 and NUM_KEYS=3 unless stated.
1. Reset: hold reset for 3 cycles with keys_raw=3'b000, then release.
   - During and immediately after reset: keys_db=3'b111, both pulse vectors 0.
   - At edge 6 after release: keys_db=3'b000 and press_pulse=3'b111 for one cycle.
2. Clean press: keys_raw[0] goes 1→0 before edge 0 and holds.
   - keys_db[0]=1 through edge 5; keys_db[0]=0 after edge 6.
   - press_pulse[0]=1 for exactly one cycle; release_pulse stays 0.
3. Bounce: keys_raw[1] toggles 0,1,0,1 every 2 cycles, then settles at 0.
   - keys_db[1] stays 1 with no pulses during the toggling.
   - keys_db[1] goes to 0 exactly 6 edges after the final settle.
4. Release: starting from a debounced pressed state, keys_raw[2] goes 0→1.
   - keys_db[2]=1 six edges later.
   - release_pulse[2]=1 for one cycle; press_pulse[2]=0.
5. Simultaneous events: keys_raw[0] and keys_raw[2] both fall before the same edge.
   - press_pulse=3'b101 in a single cycle, 6 edges later.
6. Reset mid-count: press keys_raw[0], then assert reset at edge 3 for 1 cycle while keys_raw[0] stays 0.
   - No pulse around the reset.
   - keys_db[0]=0 with press_pulse[0] at edge 6 after reset deasserts.

Source files
------------

// File: rtl/key_debouncer.sv
// Per-key two-flop synchroniser and stability-count debouncer feeding the
// keys PIO in_port (active-low levels), plus one-cycle press/release strobes.
module key_debouncer #(
    parameter int NUM_KEYS      = 3,
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_db,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;

    // Synchronisers reset to released so reset never fabricates a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= keys_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t               r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_db;
        logic                 r_press;
        logic                 r_rel;
        logic                 w_s2;

        assign w_s2 = r_sync2[i];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_db    <= 1'b1;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                unique case (r_state)
                    ST_STABLE: begin
                        if (w_s2 != r_db) begin
                            r_state <= ST_PENDING;
                            r_cnt   <= ONE;
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    ST_PENDING: begin
                        if (w_s2 == r_db) begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == LAST) begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                            r_db    <= w_s2;
                            r_press <= ~w_s2;
                            r_rel   <= w_s2;
                        end else begin
                            r_cnt   <= r_cnt + ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign keys_db[i]       = r_db;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_rel;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios with literal expectations plus
// random key activity checked every cycle against a run-length model.
module tb_key_debouncer;

    localparam int NK = 3;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys_raw = '1;
    logic [NK-1:0] keys_db;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int n_checks = 0;
    int n_errors = 0;

    key_debouncer #(
        .NUM_KEYS(NK),
        .CNT_WIDTH(16),
        .STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys_raw(keys_raw),
        .keys_db(keys_db),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Model: a pin value is seen by the debouncer two edges after sampling;
    // a new level is accepted on the S-th consecutive edge at which the seen
    // level differs from the accepted one.
    logic [NK-1:0] m_p1 = '1, m_p2 = '1, m_db = '1;
    logic [NK-1:0] m_pr = '0, m_rl = '0;
    int            m_run [NK];
    bit            m_valid = 0;

    task automatic chk(input string name, input logic [NK-1:0] act,
                       input logic [NK-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_p1 = '1; m_p2 = '1; m_db = '1; m_pr = '0; m_rl = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
        end else begin
            m_pr = '0; m_rl = '0;
            for (int i = 0; i < NK; i++) begin
                m_run[i] = (m_p2[i] != m_db[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == S) begin
                    m_db[i] = m_p2[i];
                    if (m_p2[i]) m_rl[i] = 1'b1;
                    else         m_pr[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = keys_raw;
        end
        m_valid = 1;
        #2;
        chk("model keys_db", keys_db, m_db);
        chk("model press_pulse", press_pulse, m_pr);
        chk("model release_pulse", release_pulse, m_rl);
    end

    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic drive(input logic [NK-1:0] v);
        @(negedge clk);
        keys_raw = v;
    endtask

    task automatic settle();
        at_edge(10);
        chk("settled press", press_pulse, 3'b000);
        chk("settled release", release_pulse, 3'b000);
    endtask

    initial begin
        // 1. Reset with all keys held
        keys_raw = 3'b000;
        reset = 1'b1;
        at_edge(1);
        chk("t1 db in reset", keys_db, 3'b111);
        chk("t1 press in reset", press_pulse, 3'b000);
        at_edge(2);
        chk("t1 rel in reset", release_pulse, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        at_edge(1);
        chk("t1 db after reset", keys_db, 3'b111);
        chk("t1 press after reset", press_pulse, 3'b000);
        at_edge(4);
        chk("t1 db edge5", keys_db, 3'b111);
        at_edge(1);
        chk("t1 db edge6", keys_db, 3'b000);
        chk("t1 press edge6", press_pulse, 3'b111);
        at_edge(1);
        chk("t1 press edge7", press_pulse, 3'b000);

        drive(3'b111);
        settle();
        chk("release all db", keys_db, 3'b111);

        // 2. Clean press on key 0
        drive(3'b110);
        at_edge(5);
        chk("t2 db edge5", keys_db, 3'b111);
        chk("t2 press edge5", press_pulse, 3'b000);
        at_edge(1);
        chk("t2 db edge6", keys_db, 3'b110);
        chk("t2 press edge6", press_pulse, 3'b001);
        chk("t2 rel edge6", release_pulse, 3'b000);
        at_edge(1);
        chk("t2 press edge7", press_pulse, 3'b000);

        // 3. Bounce on key 1, then settle pressed
        for (int k = 0; k < 4; k++) begin
            drive((k % 2 == 0) ? 3'b100 : 3'b110);
            for (int c = 0; c < 2; c++) begin
                at_edge(1);
                chk("t3 db bounce", keys_db & 3'b010, 3'b010);
                chk("t3 pulse bounce",
                    (press_pulse | release_pulse) & 3'b010, 3'b000);
            end
        end
        drive(3'b100);
        at_edge(5);
        chk("t3 db edge5", keys_db, 3'b110);
        at_edge(1);
        chk("t3 db edge6", keys_db, 3'b100);
        chk("t3 press edge6", press_pulse, 3'b010);

        // 4. Release of key 2 from a pressed state
        drive(3'b000);
        settle();
        chk("t4 pressed db", keys_db, 3'b000);
        drive(3'b100);
        at_edge(5);
        chk("t4 db edge5", keys_db, 3'b000);
        at_edge(1);
        chk("t4 db edge6", keys_db, 3'b100);
        chk("t4 rel edge6", release_pulse, 3'b100);
        chk("t4 press edge6", press_pulse, 3'b000);

        // 5. Simultaneous presses on keys 0 and 2
        drive(3'b111);
        settle();
        drive(3'b010);
        at_edge(5);
        chk("t5 press edge5", press_pulse, 3'b000);
        at_edge(1);
        chk("t5 press edge6", press_pulse, 3'b101);
        at_edge(1);
        chk("t5 press edge7", press_pulse, 3'b000);

        // 6. Reset in the middle of a count
        drive(3'b111);
        settle();
        drive(3'b110);
        at_edge(2);
        @(negedge clk);
        reset = 1'b1;
        at_edge(1);
        chk("t6 db in reset", keys_db, 3'b111);
        chk("t6 press in reset", press_pulse, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        at_edge(5);
        chk("t6 db edge5", keys_db, 3'b111);
        chk("t6 press edge5", press_pulse, 3'b000);
        at_edge(1);
        chk("t6 db edge6", keys_db, 3'b110);
        chk("t6 press edge6", press_pulse, 3'b001);

        // Random key activity with occasional reset
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 3) == 0)
                keys_raw = NK'($urandom);
            else
                keys_raw[$urandom_range(0, NK - 1)] ^= 1'b1;
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        at_edge(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
